// File: rtl/aes_encrypt_iter.sv
// aes_encrypt_iter: iterative AES-128/192/256 encryptor, one round per clock, cached key schedule.
// Define AES_ZEROIZE_EN to add a zeroize input that wipes schedule, state and output registers.
module aes_encrypt_iter #(
  parameter int NB     = 4,
  parameter int MAX_NK = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] key_in,
  input  logic [1:0]   key_len,
  input  logic         key_load,
  output logic         key_ready,
  output logic         key_err,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
`ifdef AES_ZEROIZE_EN
  input  logic         zeroize,
`endif
  output logic         busy
);
  localparam int WN = NB * (MAX_NK + 7);
  localparam int IW = $clog2(WN);
  localparam logic [3:0] MNK = 4'(MAX_NK);
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  if (NB != 4) begin : g_nb_check
    $error("aes_encrypt_iter: NB must be 4");
  end

  typedef enum logic [1:0] {IDLE, KEXP, ROUND, HOLD} state_t;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // SubBytes + ShiftRows, then MixColumns unless this is the final round
  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic last);
    logic [7:0] b [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        b[4*c+r] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
    for (int c = 0; c < 4; c++) begin
      a0 = b[4*c]; a1 = b[4*c+1]; a2 = b[4*c+2]; a3 = b[4*c+3];
      o[127-32*c -: 32] = last ? {a0, a1, a2, a3} :
        {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3, a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
         a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3, xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    end
    return o;
  endfunction

  state_t         state_q, state_d;
  logic [31:0]    w_q [WN];
  logic [31:0]    w_d [WN];
  logic [IW-1:0]  i_q, i_d;
  logic [2:0]     j_q, j_d;
  logic [7:0]     rc_q, rc_d;
  logic [3:0]     nk_q, nk_d, nr_q, nr_d, r_q, r_d;
  logic [127:0]   s_q, s_d, out_data_q, out_data_d;
  logic           out_valid_q, out_valid_d, key_ready_q, key_ready_d, key_err_q, key_err_d;
  logic [3:0]     nk_in;
  logic           kl_bad, kl_ok, acc, kexp_last, rnd_last, zz;
  logic [31:0]    prv, tmp;
  logic [127:0]   rk, rk0, rnd;

`ifdef AES_ZEROIZE_EN
  assign zz = zeroize;
`else
  assign zz = 1'b0;
`endif

  assign nk_in     = key_len == 2'd0 ? 4'd4 : key_len == 2'd1 ? 4'd6 : 4'd8;
  assign kl_bad    = key_load & (key_len == 2'd3 | nk_in > MNK);
  assign kl_ok     = key_load & ~kl_bad;
  assign acc       = in_valid & in_ready;
  assign kexp_last = i_q == IW'({nr_q, 2'b11});
  assign rnd_last  = r_q == nr_q;

  always_ff @(posedge clk or negedge rst)
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = kl_ok ? KEXP : acc ? ROUND : IDLE;
      KEXP:    state_d = kexp_last ? IDLE : KEXP;
      ROUND:   state_d = rnd_last ? HOLD : ROUND;
      default: state_d = out_ready ? IDLE : HOLD;
    endcase
    if (zz) state_d = IDLE;
  end

  always_comb begin
    busy     = state_q != IDLE;
    in_ready = state_q == IDLE & key_ready_q & ~key_load;
  end

  always_comb begin
    w_d = w_q;
    i_d = i_q;
    j_d = j_q;
    rc_d = rc_q;
    nk_d = nk_q;
    nr_d = nr_q;
    r_d = r_q;
    s_d = s_q;
    out_data_d = out_data_q;
    out_valid_d = out_valid_q;
    key_ready_d = key_ready_q;
    key_err_d = 1'b0;
    prv = w_q[i_q - IW'(1)];
    tmp = j_q == 3'd0 ? sub_word({prv[23:0], prv[31:24]}) ^ {rc_q, 24'h0} :
          (nk_q == 4'd8 && j_q == 3'd4) ? sub_word(prv) : prv;
    rk  = {w_q[IW'({r_q, 2'd0})], w_q[IW'({r_q, 2'd1})], w_q[IW'({r_q, 2'd2})], w_q[IW'({r_q, 2'd3})]};
    rk0 = {w_q[0], w_q[1], w_q[2], w_q[3]};
    rnd = aes_round(s_q, rnd_last) ^ rk;
    if (state_q == IDLE && kl_bad) begin
      key_err_d = 1'b1;
      key_ready_d = 1'b0;
    end
    if (state_q == IDLE && kl_ok) begin
      for (int k = 0; k < MAX_NK; k++)
        if (4'(k) < nk_in) w_d[k] = key_in[255-32*k -: 32];
      nk_d = nk_in;
      nr_d = nk_in + 4'd6;
      i_d = IW'(nk_in);
      j_d = 3'd0;
      rc_d = 8'h01;
      key_ready_d = 1'b0;
    end
    if (acc) begin
      s_d = in_data ^ rk0;
      r_d = 4'd1;
    end
    if (state_q == KEXP) begin
      w_d[i_q] = w_q[i_q - IW'(nk_q)] ^ tmp;
      i_d = i_q + IW'(1);
      j_d = j_q == 3'(nk_q - 4'd1) ? 3'd0 : j_q + 3'd1;
      rc_d = j_q == 3'd0 ? xt(rc_q) : rc_q;
      key_ready_d = kexp_last;
    end
    if (state_q == ROUND) begin
      if (rnd_last) begin
        out_data_d = rnd;
        out_valid_d = 1'b1;
      end else begin
        s_d = rnd;
        r_d = r_q + 4'd1;
      end
    end
    if (state_q == HOLD && out_ready) out_valid_d = 1'b0;
    if (zz) begin
      w_d = '{default: '0};
      s_d = '0;
      out_data_d = '0;
      out_valid_d = 1'b0;
      key_ready_d = 1'b0;
      key_err_d = 1'b0;
      nk_d = '0;
      nr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      i_q <= '0;
      j_q <= '0;
      rc_q <= '0;
      nk_q <= '0;
      nr_q <= '0;
      r_q <= '0;
      s_q <= '0;
      out_data_q <= '0;
      out_valid_q <= 1'b0;
      key_ready_q <= 1'b0;
      key_err_q <= 1'b0;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
      rc_q <= rc_d;
      nk_q <= nk_d;
      nr_q <= nr_d;
      r_q <= r_d;
      s_q <= s_d;
      out_data_q <= out_data_d;
      out_valid_q <= out_valid_d;
      key_ready_q <= key_ready_d;
      key_err_q <= key_err_d;
    end

  // schedule contents are don't-care after reset, so the store carries no reset
  always_ff @(posedge clk) w_q <= w_d;

  assign key_ready = key_ready_q;
  assign key_err   = key_err_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
endmodule

// File: tb/tb_aes_encrypt_iter.sv
// tb_aes_encrypt_iter: directed + randomized checks of aes_encrypt_iter against an algebraic AES model.
module tb_aes_encrypt_iter;
  logic clk = 1'b0, rst = 1'b0;
  logic [255:0] key_in = '0;
  logic [1:0] key_len = '0;
  logic key_load = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic key_ready, key_err, in_ready, out_valid, busy;
  logic [127:0] in_data = '0, out_data;
`ifdef AES_ZEROIZE_EN
  logic zeroize = 1'b0;
`endif
  int errors = 0, checks = 0;
  logic [7:0] sb_t [256];

  aes_encrypt_iter dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_len(key_len), .key_load(key_load),
    .key_ready(key_ready), .key_err(key_err), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef AES_ZEROIZE_EN
    .zeroize(zeroize),
`endif
    .busy(busy));

  always #5 clk = ~clk;

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] b, input int k);
    logic [15:0] d;
    d = {b, b} << k;
    return d[15:8];
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sb_t[t[31:24]], sb_t[t[23:16]], sb_t[t[15:8]], sb_t[t[7:0]]};
  endfunction

  function automatic logic [127:0] ref_enc(input logic [255:0] key, input int nk, input logic [127:0] pt);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0] rc;
    logic [7:0] st [4][4];
    logic [7:0] sh [4][4];
    logic [127:0] o;
    int nr;
    nr = nk + 6;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    rc = 8'h01;
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) t = subw(t);
      w[i] = w[i-nk] ^ t;
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) st[r][c] = pt[127-8*(4*c+r) -: 8] ^ w[c][31-8*r -: 8];
    for (int k = 1; k <= nr; k++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) sh[r][c] = sb_t[st[r][(c+r)%4]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          st[r][c] = (k == nr ? sh[r][c] : gm(8'h02, sh[r][c]) ^ gm(8'h03, sh[(r+1)%4][c]) ^
                      sh[(r+2)%4][c] ^ sh[(r+3)%4][c]) ^ w[4*k+c][31-8*r -: 8];
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) o[127-8*(4*c+r) -: 8] = st[r][c];
    return o;
  endfunction

  function automatic logic [127:0] r128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load_key(input logic [255:0] k, input logic [1:0] len, input int exp_n, input string tag);
    int n;
    n = 0;
    key_in = k;
    key_len = len;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    key_in = {r128(), r128()};
    key_len = 2'd3;
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_kr_clear"}, key_ready, 0);
    while (!key_ready && n < 200) begin tick(); n++; end
    chk({tag, "_kexp_cycles"}, n, exp_n);
    chk({tag, "_idle"}, busy, 0);
  endtask

  task automatic run_block(input logic [127:0] pt, input logic [127:0] exp, input int nr, input string tag);
    int n;
    n = 0;
    out_ready = 1'b1;
    while (!in_ready && n < 100) begin tick(); n++; end
    chk({tag, "_in_ready"}, in_ready, 1);
    in_valid = 1'b1;
    in_data = pt;
    tick();
    in_valid = 1'b0;
    in_data = r128();
    n = 0;
    while (!out_valid && n < 100) begin tick(); n++; end
    chk({tag, "_latency"}, n, nr);
    chk({tag, "_data"}, out_data, exp);
    tick();
    chk({tag, "_period"}, in_ready, 1);
    chk({tag, "_ov_drop"}, out_valid, 0);
  endtask

  initial begin
    logic [7:0] p;
    logic [255:0] k128, k192, k256, k;
    logic [127:0] pt, exp, held;
    logic [1:0] len;
    int n, nk;
    for (int x = 0; x < 256; x++) begin
      p = 8'h01;
      for (int i = 0; i < 254; i++) p = gm(p, 8'(x));
      sb_t[x] = p ^ rl(p, 1) ^ rl(p, 2) ^ rl(p, 3) ^ rl(p, 4) ^ 8'h63;
    end
    k128 = {128'h000102030405060708090a0b0c0d0e0f, r128()};
    k192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    k256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    pt = 128'h00112233445566778899aabbccddeeff;

    tick();
    tick();
    chk("rst_key_ready", key_ready, 0);
    chk("rst_key_err", key_err, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 0);
    rst = 1'b1;
    tick();

    load_key(k128, 2'd0, 40, "kat128");
    run_block(pt, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 10, "kat128");
    load_key(k192, 2'd1, 46, "kat192");
    run_block(pt, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, 12, "kat192");
    load_key(k256, 2'd2, 52, "kat256");
    run_block(pt, 128'h8ea2b7ca516745bfeafc49904b496089, 14, "kat256");

    pt = r128();
    exp = ref_enc(k256, 8, pt);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = pt;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin tick(); n++; end
    chk("stall_latency", n, 14);
    held = out_data;
    chk("stall_data", held, exp);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("stall_hold", out_data, held);
      chk("stall_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    chk("stall_release", out_valid, 0);
    for (int i = 0; i < 4; i++) begin
      pt = r128();
      run_block(pt, ref_enc(k256, 8, pt), 14, "b2b");
    end

    for (int i = 0; i < 3; i++) begin
      len = 2'($urandom_range(0, 2));
      nk = 4 + 2 * int'(len);
      k = {r128(), r128()};
      load_key(k, len, 3 * nk + 28, "rndkey");
      pt = r128();
      run_block(pt, ref_enc(k, nk, pt), nk + 6, "rndblk");
    end

    key_in = {r128(), r128()};
    key_len = 2'd3;
    key_load = 1'b1;
    #1;
    chk("err_in_ready_pre", in_ready, 0);
    tick();
    key_load = 1'b0;
    chk("err_pulse", key_err, 1);
    chk("err_key_ready", key_ready, 0);
    chk("err_busy", busy, 0);
    tick();
    chk("err_pulse_end", key_err, 0);
    chk("err_in_ready", in_ready, 0);

    load_key(k128, 2'd0, 40, "reload");
    key_in = k192;
    key_len = 2'd1;
    key_load = 1'b1;
    in_valid = 1'b1;
    in_data = 128'h00112233445566778899aabbccddeeff;
    #1;
    chk("coll_in_ready", in_ready, 0);
    tick();
    key_load = 1'b0;
    in_valid = 1'b0;
    chk("coll_busy", busy, 1);
    chk("coll_key_ready", key_ready, 0);
    n = 0;
    while (!key_ready && n < 200) begin tick(); n++; end
    chk("coll_kexp_cycles", n, 46);
    run_block(128'h00112233445566778899aabbccddeeff, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, 12, "coll");

    in_valid = 1'b1;
    in_data = r128();
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    rst = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_key_ready", key_ready, 0);
    chk("arst_busy", busy, 0);
    chk("arst_out_data", out_data, 0);
    tick();
    rst = 1'b1;
    repeat (16) tick();
    chk("arst_no_output", out_valid, 0);
    chk("arst_still_no_key", key_ready, 0);

`ifdef AES_ZEROIZE_EN
    load_key(k128, 2'd0, 40, "zkey");
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = r128();
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin tick(); n++; end
    chk("zero_latency", n, 10);
    zeroize = 1'b1;
    tick();
    zeroize = 1'b0;
    chk("zero_out_valid", out_valid, 0);
    chk("zero_out_data", out_data, 0);
    chk("zero_key_ready", key_ready, 0);
    chk("zero_busy", busy, 0);
    out_ready = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
